// File: rtl/sd_sector_responder.sv
// Target-side sector responder: moves one 256-word sector between the sd_buff_* buffer port and a word store.
// Define SD_RESP_READONLY_EN to sequence writes without storing them (err is raised for every write).
`timescale 1ns/1ps

module sd_sector_responder #(
    parameter int SEC_W  = 7,
    parameter int ADDR_W = SEC_W + 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [7:0]        sd_buff_addr,
    output logic [15:0]       sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [15:0]       sd_buff_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_WAIT, WR_SAMP, WR_REQ, DONE
    } state_t;

`ifdef SD_RESP_READONLY_EN
    localparam logic WR_STORE_EN = 1'b0;
`else
    localparam logic WR_STORE_EN = 1'b1;
`endif

    state_t           state_q, state_d;
    logic [SEC_W-1:0] lba_q, lba_d;
    logic [7:0]       word_q, word_d;
    logic [7:0]       addr_q, addr_d;
    logic [15:0]      dout_q, dout_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             err_q, err_d;

    logic lba_oor;
    logic last_word;

    assign lba_oor   = |sd_lba[31:SEC_W];
    assign last_word = (word_q == 8'hFF);

    // Store handshake: mem_req is held with addr/we/wdata stable until a one-cycle mem_ack.
    // err_q doubles as the "skip the store" flag: an out-of-range or suppressed write never
    // raises mem_req and completes as if mem_ack came one cycle after the request.
    always_comb begin
        state_d = state_q;
        lba_d   = lba_q;
        word_d  = word_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (sd_rd || sd_wr) begin
                    lba_d   = sd_lba[SEC_W-1:0];
                    word_d  = 8'd0;
                    err_d   = lba_oor | (~WR_STORE_EN & ~sd_rd);
                    state_d = sd_rd ? RD_REQ : WR_ADDR;
                end
            end
            RD_REQ: begin
                if (err_q || mem_ack) begin
                    dout_d  = err_q ? 16'hFFFF : mem_rdata;
                    addr_d  = word_q;
                    state_d = RD_PUT;
                end
            end
            RD_PUT: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    word_d  = word_q + 8'd1;
                    state_d = RD_REQ;
                end
            end
            WR_ADDR: begin
                addr_d  = word_q;
                state_d = WR_WAIT;
            end
            WR_WAIT: state_d = WR_SAMP;
            // Buffer RAM has one cycle of latency; data is taken two cycles after the address.
            WR_SAMP: begin
                wdata_d = sd_buff_din;
                state_d = WR_REQ;
            end
            WR_REQ: begin
                if (err_q || mem_ack) begin
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        word_d  = word_q + 8'd1;
                        state_d = WR_ADDR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lba_q   <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lba_q   <= lba_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign sd_ack       = (state_q != IDLE) && (state_q != DONE);
    assign busy         = (state_q != IDLE);
    assign sd_buff_addr = addr_q;
    assign sd_buff_dout = dout_q;
    assign sd_buff_wr   = (state_q == RD_PUT);
    assign mem_addr     = ADDR_W'({lba_q, word_q});
    assign mem_req      = ((state_q == RD_REQ) || (state_q == WR_REQ)) && !err_q;
    assign mem_we       = (state_q == WR_REQ) && !err_q;
    assign mem_wdata    = wdata_q;
    assign err          = err_q;

endmodule

// File: doc/sd_sector_responder.md
# sd_sector_responder

Target-side responder for the sector protocol used by the backup-RAM save/load logic (`sd_lba`, `sd_rd`, `sd_wr`, `sd_ack`, `sd_buff_*`). It services one 512-byte sector (256 × 16-bit words) per request by moving data between the sector buffer interface and a word-addressed backing store. It sits where the host-side block device normally sits, so save/load paths can run on-chip against block RAM or DDR (simulation, standalone builds) without HPS involvement.

## Interface
Parameters:
- `SEC_W`, default 7: LBA bits used; capacity is 2^SEC_W sectors.
- `ADDR_W`, default SEC_W+8: backing-store word address width.

Ports:
- `clk_sys`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `sd_lba`  in  32  sector number, sampled at accept
- `sd_rd`  in  1  read request (store → buffer), level
- `sd_wr`  in  1  write request (buffer → store), level
- `sd_ack`  out  1  high for the whole sector transfer
- `sd_buff_addr`  out  8  word index within sector
- `sd_buff_dout`  out  16  read data to initiator buffer
- `sd_buff_wr`  out  1  one-cycle write strobe for `sd_buff_dout`
- `sd_buff_din`  in  16  write data from initiator buffer (registered RAM, 1-cycle latency)
- `mem_addr`  out  ADDR_W  {lba[SEC_W-1:0], word}
- `mem_req`  out  1  held until `mem_ack`
- `mem_we`  out  1  1 = write, qualified by `mem_req`
- `mem_wdata`  out  16  store write data
- `mem_rdata`  in  16  store read data, valid with `mem_ack`
- `mem_ack`  in  1  one-cycle completion pulse
- `busy`  out  1  state ≠ IDLE
- `err`  out  1  sticky: last accepted LBA ≥ 2^SEC_W

## Operation
- States: IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_WAIT, WR_SAMP, WR_REQ, DONE.
- IDLE: if `sd_rd|sd_wr`, latch `sd_lba` and direction (`sd_rd` wins if both), clear word counter, set `err` = (`sd_lba[31:SEC_W]` ≠ 0), raise `sd_ack`, go RD_REQ or WR_ADDR.
- Read: RD_REQ drives `mem_req`=1, `mem_we`=0 until `mem_ack`; data captured into `sd_buff_dout`; RD_PUT pulses `sd_buff_wr` with `sd_buff_addr`=word; word 255 → DONE, else increment, RD_REQ.
- Write: WR_ADDR drives `sd_buff_addr`=word; WR_WAIT one cycle; WR_SAMP captures `sd_buff_din` into `mem_wdata`; WR_REQ holds `mem_req`=1, `mem_we`=1 until `mem_ack`; word 255 → DONE, else increment, WR_ADDR.
- Out-of-range LBA: no `mem_req` issued; reads supply 16'hFFFF per word; writes discarded; timing as if `mem_ack` arrived the cycle after request.
- DONE: drop `sd_ack`, return to IDLE; a request is not accepted in the DONE cycle (≥1 cycle `sd_ack` low between sectors).
- Word counter 8 bits, stops at 255, never wraps within a sector.
- Requests arriving while busy are ignored; initiator clears `sd_rd/sd_wr` on `sd_ack` rise.

## Timing
- Reset values: all outputs 0, state IDLE, `err` 0. Async reset mid-transfer aborts immediately; `mem_req` drops, outstanding store transaction is abandoned.
- Accept at edge t → `sd_ack`=1 from t+1.
- Read word: `mem_req` to `mem_ack` latency L ≥ 1; `sd_buff_wr` pulses the cycle after `mem_ack`; per-word cost L+1 cycles.
- Write word: `sd_buff_din` sampled exactly 2 cycles after `sd_buff_addr` update; per-word cost 3+L cycles.
- `sd_ack` falls the cycle after the last word completes (read: after `sd_buff_wr` for word 255; write: after `mem_ack` for word 255).
- `mem_addr`, `mem_we`, `mem_wdata` stable while `mem_req`=1.

## Configuration
- `SD_RESP_READONLY_EN`: when defined, write requests are accepted and complete with normal `sd_buff_addr` sequencing and `sd_ack` timing, but `mem_req` is never asserted for writes and `err` is set for every write request. When undefined, writes go to the store as above.

## Test plan
- Read LBA 3, store holds word = addr ^ 16'h5A5A, L=1 → 256 `sd_buff_wr` pulses, addr 0..255, data (0x300+i)^0x5A5A, `sd_ack` high 512 cycles.
- Write LBA 0 from buffer pattern i*3, L=4 → store words 0..255 = i*3, sampled 2 cycles after each addr, `sd_ack` low after final ack.
- Read LBA 200 (SEC_W=7) → no `mem_req`, 256 words of 16'hFFFF, `err`=1; next in-range request clears `err`.
- `sd_rd` and `sd_wr` asserted same cycle → read performed; `sd_rd` held through DONE → second read starts only after 1 cycle with `sd_ack`=0.
- `reset_n` low at word 100 of a write → `sd_ack`, `mem_req`, `busy` 0 asynchronously; fresh request after release starts at word 0.
- With `SD_RESP_READONLY_EN`: write LBA 1 → full sequencing, zero `mem_req`, `err`=1.
